// File: rtl/branch_pht.sv
// Gshare direction predictor: a PC-xor-history indexed table of 2-bit saturating
// counters with a speculatively updated global history register and EX-side repair.
module branch_pht #(
  parameter  int SIZE  = 1024,
  localparam int INDEX = $clog2(SIZE)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [29:0]      PC_IF,
  input  logic             btb_valid,
  input  logic             btb_jump,
  input  logic             stall_IF,
  input  logic [29:0]      PC_EX,
  input  logic             branch_EX,
  input  logic             taken_EX,
  input  logic [INDEX-1:0] ghr_EX,
  input  logic             mispredict_EX,
  output logic             predict_taken,
  output logic [INDEX-1:0] ghr_IF
);

  localparam logic [1:0] CNT_RESET = 2'b01;

  logic [1:0]       cnt_q [SIZE];
  logic [INDEX-1:0] ghr_q;
  logic [INDEX-1:0] ghr_d;

  logic [INDEX-1:0] idx_if;
  logic [INDEX-1:0] idx_ex;
  logic             cnt_if_taken;
  logic [1:0]       cnt_upd_d;
  logic             spec_shift;

  logic unused_pc_hi;
  assign unused_pc_hi = ^{PC_IF[29:INDEX], PC_EX[29:INDEX]};

  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic up);
    logic [1:0] res;
    res = cnt;
    if (up) begin
      if (cnt != 2'b11) res = cnt + 2'd1;
    end else begin
      if (cnt != 2'b00) res = cnt - 2'd1;
    end
    return res;
  endfunction

  // Fetch side: prediction reads the table before this cycle's EX write lands.
  assign idx_if        = PC_IF[INDEX-1:0] ^ ghr_q;
  assign cnt_if_taken  = cnt_q[idx_if][1];
  assign predict_taken = btb_valid & (btb_jump | cnt_if_taken);
  assign ghr_IF        = ghr_q;

  assign idx_ex     = PC_EX[INDEX-1:0] ^ ghr_EX;
  assign cnt_upd_d  = sat_update(cnt_q[idx_ex], taken_EX);
  assign spec_shift = btb_valid & ~btb_jump & ~stall_IF;

  // History repair from EX takes priority over the speculative fetch shift.
  always_comb begin
    ghr_d = ghr_q;
    if (mispredict_EX) begin
      if (branch_EX) ghr_d = {ghr_EX[INDEX-2:0], taken_EX};
      else           ghr_d = ghr_EX;
    end else if (spec_shift) begin
      ghr_d = {ghr_q[INDEX-2:0], cnt_if_taken};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < SIZE; i++) cnt_q[i] <= CNT_RESET;
    end else if (branch_EX) begin
      cnt_q[idx_ex] <= cnt_upd_d;
    end
  end

endmodule

// File: tb/tb_branch_pht.sv
// Directed bench for branch_pht: expected outputs queued at drive time, popped and checked on sampling.
module tb_branch_pht;

  localparam int SIZE  = 1024;
  localparam int INDEX = 10;

  logic             clk;
  logic             rstn;
  logic [29:0]      PC_IF;
  logic             btb_valid;
  logic             btb_jump;
  logic             stall_IF;
  logic [29:0]      PC_EX;
  logic             branch_EX;
  logic             taken_EX;
  logic [INDEX-1:0] ghr_EX;
  logic             mispredict_EX;
  logic             predict_taken;
  logic [INDEX-1:0] ghr_IF;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string            tag;
    logic             chk_pred;
    logic             pred;
    logic [INDEX-1:0] ghr;
  } exp_t;

  exp_t sb[$];

  branch_pht #(.SIZE(SIZE)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .PC_IF         (PC_IF),
    .btb_valid     (btb_valid),
    .btb_jump      (btb_jump),
    .stall_IF      (stall_IF),
    .PC_EX         (PC_EX),
    .branch_EX     (branch_EX),
    .taken_EX      (taken_EX),
    .ghr_EX        (ghr_EX),
    .mispredict_EX (mispredict_EX),
    .predict_taken (predict_taken),
    .ghr_IF        (ghr_IF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  task automatic push(input string tag, input logic cp, input logic p, input logic [INDEX-1:0] g);
    exp_t e;
    e.tag      = tag;
    e.chk_pred = cp;
    e.pred     = p;
    e.ghr      = g;
    sb.push_back(e);
  endtask

  task automatic sample();
    exp_t e;
    #2;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=none expected=entry");
    end else begin
      e = sb.pop_front();
      if (e.chk_pred) begin
        checks++;
        assert (predict_taken === e.pred)
        else begin
          errors++;
          $error("FAIL %s predict_taken observed=%b expected=%b", e.tag, predict_taken, e.pred);
        end
      end
      checks++;
      assert (ghr_IF === e.ghr)
      else begin
        errors++;
        $error("FAIL %s ghr_IF observed=%h expected=%h", e.tag, ghr_IF, e.ghr);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic p, input logic [INDEX-1:0] g);
    push(tag, 1'b1, p, g);
    sample();
  endtask

  initial begin
    rstn = 1'b0; PC_IF = 30'h10; btb_valid = 1'b1; btb_jump = 1'b0; stall_IF = 1'b0;
    PC_EX = '0; branch_EX = 1'b0; taken_EX = 1'b0; ghr_EX = '0; mispredict_EX = 1'b0;

    // Reset: counters weakly not-taken, history clear.
    chk("rst_cond", 1'b0, 10'h000);
    btb_jump = 1'b1;
    chk("rst_jump", 1'b1, 10'h000);
    step();
    rstn = 1'b1;
    btb_jump = 1'b0;
    chk("if_nt_after_rst", 1'b0, 10'h000);
    step();

    // Counter 5 saturating walk; IF stalled so history stays 0.
    stall_IF = 1'b1; PC_IF = 30'h5;
    branch_EX = 1'b1; taken_EX = 1'b1; PC_EX = 30'h5; ghr_EX = 10'h000;
    chk("ghr_stays0_cnt01", 1'b0, 10'h000); step();
    chk("cnt10", 1'b1, 10'h000); step();
    chk("cnt11", 1'b1, 10'h000); step();
    taken_EX = 1'b0;
    chk("cnt11_sat", 1'b1, 10'h000); step();
    chk("dec_to10", 1'b1, 10'h000); step();
    chk("dec_to01", 1'b0, 10'h000); step();
    chk("dec_to00", 1'b0, 10'h000); step();
    branch_EX = 1'b0; taken_EX = 1'b1;
    chk("cnt00_sat", 1'b0, 10'h000);

    // Counter 3 -> 10, then stalled vs unstalled speculative shift.
    branch_EX = 1'b1; taken_EX = 1'b1; PC_EX = 30'h3; PC_IF = 30'h3;
    chk("cnt3_preupdate", 1'b0, 10'h000); step();
    branch_EX = 1'b0; taken_EX = 1'b0;
    chk("stall_pred_t", 1'b1, 10'h000); step();
    stall_IF = 1'b0;
    chk("stall_no_shift", 1'b1, 10'h000); step();
    stall_IF = 1'b1;
    chk("xor_idx2", 1'b0, 10'h001);
    PC_IF = 30'h2;
    chk("xor_idx3", 1'b1, 10'h001);

    // Jump-target repair load, then branch repair overriding a speculative shift.
    mispredict_EX = 1'b1; ghr_EX = 10'h00F; PC_EX = 30'h3FF; taken_EX = 1'b1;
    chk("pre_load_f", 1'b1, 10'h001); step();
    branch_EX = 1'b1; taken_EX = 1'b0; ghr_EX = 10'h002; PC_EX = 30'h0;
    stall_IF = 1'b0; PC_IF = 30'h00C;
    chk("ghr_0f_spec_t", 1'b1, 10'h00F); step();
    taken_EX = 1'b1; ghr_EX = 10'h155; PC_EX = 30'h155; stall_IF = 1'b1; PC_IF = 30'h0;
    chk("repair_nt_004", 1'b0, 10'h004); step();
    branch_EX = 1'b0; PC_EX = 30'h2AA; PC_IF = 30'h2AB;
    chk("repair_t_2ab", 1'b1, 10'h2AB); step();

    // Jump hit predicts taken regardless of counter and leaves history alone.
    mispredict_EX = 1'b0; btb_jump = 1'b1; stall_IF = 1'b0; PC_IF = 30'h157;
    ghr_EX = 10'h3FF; PC_EX = 30'h3FF;
    chk("jump_155", 1'b1, 10'h155); step();
    btb_jump = 1'b0; stall_IF = 1'b1;
    chk("jump_no_shift_cnt00", 1'b0, 10'h155);
    btb_valid = 1'b0; stall_IF = 1'b0; PC_IF = 30'h155;
    chk("btb_miss", 1'b0, 10'h155); step();
    btb_valid = 1'b1;
    chk("miss_no_shift", 1'b1, 10'h155); step();
    stall_IF = 1'b1; PC_IF = 30'h2AB;
    chk("spec_shift_t", 1'b1, 10'h2AB);

    // Same-index read/write: prediction uses the old value.
    branch_EX = 1'b1; taken_EX = 1'b1; PC_EX = 30'h4; ghr_EX = 10'h000; PC_IF = 30'h2AF;
    chk("raw_old", 1'b0, 10'h2AB); step();
    branch_EX = 1'b0;
    chk("raw_new", 1'b1, 10'h2AB);

    // Reset pulse between edges clears everything immediately.
    rstn = 1'b0;
    PC_IF = 30'h0;
    chk("pulse_low", 1'b0, 10'h000);
    rstn = 1'b1;
    chk("pulse_high_cnt0", 1'b0, 10'h000);
    PC_IF = 30'h4;
    chk("pulse_high_cnt4", 1'b0, 10'h000);
    step();
    chk("post_pulse_edge", 1'b0, 10'h000);

    checks++;
    assert (sb.size() == 0)
    else begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_pht.md
BRANCH_PHT -- requirements
Module: branch_pht

Interface
REQ-001 SHALL have parameter SIZE, default 1024, number of 2-bit counters (power of two); INDEX = log2(SIZE) SHALL also be the global history length.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rstn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port PC_IF  input  30  fetch PC[31:2].
REQ-005 SHALL have port btb_valid  input  1  BTB hit for PC_IF.
REQ-006 SHALL have port btb_jump  input  1  BTB entry is an unconditional jump.
REQ-007 SHALL have port stall_IF  input  1  fetch held; no speculative history update.
REQ-008 SHALL have port PC_EX  input  30  PC[31:2] of instruction in EX.
REQ-009 SHALL have port branch_EX  input  1  conditional branch resolved in EX this cycle.
REQ-010 SHALL have port taken_EX  input  1  actual branch outcome.
REQ-011 SHALL have port ghr_EX  input  INDEX  history snapshot carried down the pipeline with the EX instruction.
REQ-012 SHALL have port mispredict_EX  input  1  EX detected wrong direction or target; front end is flushed.
REQ-013 SHALL have port predict_taken  output  1  redirect fetch to BTB target.
REQ-014 SHALL have port ghr_IF  output  INDEX  history used for the current fetch, to be piped alongside the instruction.

Function
REQ-015 SHALL hold a table of SIZE 2-bit saturating counters: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-016 SHALL hold an INDEX-bit global history register GHR; newest outcome in bit 0.
REQ-017 SHALL compute idx_IF = PC_IF[INDEX-1:0] XOR GHR, combinationally.
REQ-018 SHALL drive predict_taken = btb_valid AND (btb_jump OR counter[idx_IF][1]), combinationally, zero-cycle latency.
REQ-019 SHALL drive ghr_IF = GHR, combinationally.
REQ-020 SHALL, when btb_valid=1, btb_jump=0, stall_IF=0, mispredict_EX=0, shift GHR <= {GHR[INDEX-2:0], counter[idx_IF][1]} at the edge.
REQ-021 SHALL leave GHR unchanged on a BTB miss, a jump hit, or stall_IF=1.
REQ-022 SHALL, when branch_EX=1, update counter[PC_EX[INDEX-1:0] XOR ghr_EX]: increment if taken_EX else decrement, saturating at 11 and 00.
REQ-023 SHALL, when mispredict_EX=1 and branch_EX=1, load GHR <= {ghr_EX[INDEX-2:0], taken_EX}, overriding REQ-020.
REQ-024 SHALL, when mispredict_EX=1 and branch_EX=0 (jump target error), load GHR <= ghr_EX, overriding REQ-020.
REQ-025 SHALL, when IF and EX address the same counter in one cycle, predict from the pre-update value; the update is visible the following cycle.
REQ-026 SHALL ignore taken_EX, ghr_EX and PC_EX when branch_EX=0 and mispredict_EX=0.
REQ-027 SHALL not block or stall; no ready/valid handshake; every input is sampled every cycle.

Reset
REQ-028 SHALL, while rstn=0, asynchronously set every counter to 01 and GHR to 0.
REQ-029 SHALL therefore give predict_taken = btb_valid AND btb_jump and ghr_IF = 0 during and immediately after reset.
REQ-030 SHALL, on reset asserted mid-operation, discard pending updates; the first edge after rstn rises applies normal rules.

Verification
REQ-031 SHALL cover: reset, btb_valid=1, btb_jump=0, PC_IF=0x10 -> predict_taken=0, ghr_IF=0; next edge GHR stays 0 (predicted NT shifts in 0).
REQ-032 SHALL cover: SIZE=1024, branch_EX=1, taken_EX=1, PC_EX=0x5, ghr_EX=0 on two edges -> counter[5] goes 01->10->11; a third taken leaves 11; four not-taken edges give 10,01,00,00.
REQ-033 SHALL cover: counter[3]=10, GHR=0, btb_valid=1, btb_jump=0, PC_IF=0x3, stall_IF=0 -> predict_taken=1, then GHR=0x001; same cycle with stall_IF=1 -> GHR stays 0.
REQ-034 SHALL cover: GHR=0x00F, mispredict_EX=1, branch_EX=1, taken_EX=0, ghr_EX=0x002 with a concurrent IF speculative update -> GHR=0x004.
REQ-035 SHALL cover: mispredict_EX=1, branch_EX=0, ghr_EX=0x155 -> GHR=0x155; btb_jump=1 hit -> predict_taken=1 regardless of counter, GHR unchanged.
REQ-036 SHALL cover: same index read and written in one cycle with counter 01 and taken_EX=1 -> predict_taken=0 this cycle and 1 the next; rstn pulsed low between clock edges -> counters 01 and GHR 0 immediately.
